// File: rtl/video_capture_dma_pkg.sv
// Shared constants, register map and DMA state type for the capture DMA.
package video_capture_dma_pkg;

  localparam int unsigned BURST_LENGTH      = 64;
  localparam int unsigned PIXEL_FIFO_LENGTH = 128;
  localparam int unsigned COUNT_WIDTH       = 19;

  localparam logic [31:0] REG_CONTROL   = 32'd0;
  localparam logic [31:0] REG_FB_BASE   = 32'd4;
  localparam logic [31:0] REG_FB_LENGTH = 32'd8;
  localparam logic [31:0] REG_STATUS    = 32'd12;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIFO_DATA,
    ISSUE_ADDR,
    BURST_ACTIVE,
    WAIT_RESPONSE
  } dma_state_t;

endpackage

// File: rtl/video_capture_dma_if.sv
// I/O register bus and AXI4 write-master bundles used by the capture DMA.
interface io_bus_interface;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_en;
  logic        write_en;

  modport slave  (input address, write_data, read_en, write_en, output read_data);
  modport master (output address, write_data, read_en, write_en, input read_data);
endinterface

interface axi4_interface;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_awvalid;
  logic        s_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic        m_wvalid;
  logic        s_wready;
  logic        s_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_rready;

  modport master (output m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid,
                  m_bready, m_araddr, m_arlen, m_arvalid, m_rready,
                  input s_awready, s_wready, s_bvalid);
  modport slave  (input m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid,
                  m_bready, m_araddr, m_arlen, m_arvalid, m_rready,
                  output s_awready, s_wready, s_bvalid);
endinterface

// File: rtl/video_capture_dma_sync_fifo.sv
// Synchronous FIFO with show-ahead head, flush and almost-full threshold.
module sync_fifo #(
  parameter int unsigned WIDTH                 = 24,
  parameter int unsigned SIZE                  = 128,
  parameter int unsigned ALMOST_FULL_THRESHOLD = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             write_en,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read_en,
  output logic [WIDTH-1:0] read_data,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  localparam int unsigned PTR_W = $clog2(SIZE);

  logic [WIDTH-1:0] mem [SIZE];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_write;
  logic             do_read;

  assign do_write    = write_en && !full;
  assign do_read     = read_en && !empty;
  assign full        = (count == (PTR_W+1)'(SIZE));
  assign empty       = (count == '0);
  assign almost_full = (count >= (PTR_W+1)'(ALMOST_FULL_THRESHOLD));
  assign read_data   = mem[rd_ptr];

  // Pointer and occupancy tracking; flush discards all content.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_read)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= write_data;
  end

endmodule

// File: rtl/video_capture_dma.sv
// Capture DMA: buffers a 24-bit pixel stream and writes it as 64-beat AXI4 bursts.
module video_capture_dma
  import video_capture_dma_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  io_bus_interface.slave        io_bus,
  output logic                  frame_interrupt,
  axi4_interface.master         axi_bus,
  input  logic                  pixel_valid,
  input  logic [23:0]           pixel_data,
  input  logic                  frame_start
);

  dma_state_t             state;
  dma_state_t             next_state;
  logic                   capture_en;
  logic [31:0]            fb_base_address;
  logic [COUNT_WIDTH-1:0] fb_length;
  logic                   overflow;
  logic                   abort;
  logic [31:0]            vram_addr;
  logic [COUNT_WIDTH-1:0] in_count;
  logic [COUNT_WIDTH-1:0] out_count;
  logic [7:0]             beat_count;

  logic        fifo_flush;
  logic        fifo_push;
  logic        fifo_pop;
  logic [23:0] fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_almost_full;

  logic capturing;
  logic start_frame;
  logic pixel_drop;
  logic last_beat;
  logic frame_done;
  logic b_done;
  logic awvalid;
  logic wvalid;
  logic wlast;
  logic bready;

  assign capturing   = (state != IDLE);
  assign start_frame = (state == IDLE) && frame_start && capture_en;
  assign fifo_flush  = start_frame;
  assign fifo_push   = pixel_valid && capturing && (in_count < fb_length) && !fifo_full;
  assign pixel_drop  = pixel_valid && capturing && fifo_full;
  assign fifo_pop    = (state == BURST_ACTIVE) && axi_bus.s_wready && !fifo_empty;
  assign last_beat   = (beat_count == 8'(BURST_LENGTH - 1));
  assign frame_done  = ((out_count + COUNT_WIDTH'(BURST_LENGTH)) == fb_length);
  assign b_done      = (state == WAIT_RESPONSE) && axi_bus.s_bvalid;

  sync_fifo #(
    .WIDTH                (24),
    .SIZE                 (PIXEL_FIFO_LENGTH),
    .ALMOST_FULL_THRESHOLD(BURST_LENGTH)
  ) u_pixel_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (fifo_flush),
    .write_en   (fifo_push),
    .write_data (pixel_data),
    .read_en    (fifo_pop),
    .read_data  (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .almost_full(fifo_almost_full)
  );

  // DMA state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode and AXI handshake outputs.
  always_comb begin
    next_state = state;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    case (state)
      IDLE: begin
        if (start_frame) next_state = WAIT_FIFO_DATA;
      end
      WAIT_FIFO_DATA: begin
        if (abort || !capture_en)  next_state = IDLE;
        else if (fifo_almost_full) next_state = ISSUE_ADDR;
      end
      ISSUE_ADDR: begin
        awvalid = 1'b1;
        if (axi_bus.s_awready) next_state = BURST_ACTIVE;
      end
      BURST_ACTIVE: begin
        wvalid = 1'b1;
        wlast  = last_beat;
        if (axi_bus.s_wready && last_beat) next_state = WAIT_RESPONSE;
      end
      WAIT_RESPONSE: begin
        bready = 1'b1;
        if (axi_bus.s_bvalid) begin
          if (frame_done)                next_state = IDLE;
          else if (abort || !capture_en) next_state = IDLE;
          else                           next_state = WAIT_FIFO_DATA;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign axi_bus.m_awvalid = awvalid;
  assign axi_bus.m_awaddr  = vram_addr;
  assign axi_bus.m_awlen   = 8'(BURST_LENGTH - 1);
  assign axi_bus.m_wvalid  = wvalid;
  assign axi_bus.m_wdata   = {fifo_head, 8'h00};
  assign axi_bus.m_wstrb   = '1;
  assign axi_bus.m_wlast   = wlast;
  assign axi_bus.m_bready  = bready;
  assign axi_bus.m_arvalid = 1'b0;
  assign axi_bus.m_rready  = 1'b0;
  assign axi_bus.m_araddr  = '0;
  assign axi_bus.m_arlen   = '0;

  // Frame counters, burst address, error flags and the completion pulse.
  // The overflow clear is ordered before the sets so a same-cycle error is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vram_addr       <= '0;
      in_count        <= '0;
      out_count       <= '0;
      beat_count      <= '0;
      abort           <= 1'b0;
      overflow        <= 1'b0;
      frame_interrupt <= 1'b0;
    end else begin
      frame_interrupt <= b_done && frame_done;
      if (io_bus.write_en && (io_bus.address == BASE_ADDRESS + REG_STATUS) && io_bus.write_data[1])
        overflow <= 1'b0;
      if (start_frame) begin
        vram_addr  <= fb_base_address;
        in_count   <= '0;
        out_count  <= '0;
        beat_count <= '0;
        abort      <= 1'b0;
      end
      if (fifo_push) in_count <= in_count + 1'b1;
      if (pixel_drop) begin
        overflow <= 1'b1;
        abort    <= 1'b1;
      end
      if (frame_start && (state != IDLE)) overflow <= 1'b1;
      if (fifo_pop) beat_count <= last_beat ? '0 : beat_count + 1'b1;
      if (b_done) begin
        vram_addr <= vram_addr + 32'd256;
        out_count <= out_count + COUNT_WIDTH'(BURST_LENGTH);
      end
    end
  end

  // Control registers and registered status readback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capture_en       <= 1'b0;
      fb_base_address  <= '0;
      fb_length        <= '0;
      io_bus.read_data <= '0;
    end else begin
      if (io_bus.write_en) begin
        if (io_bus.address == BASE_ADDRESS + REG_CONTROL)   capture_en      <= io_bus.write_data[0];
        if (io_bus.address == BASE_ADDRESS + REG_FB_BASE)   fb_base_address <= io_bus.write_data;
        if (io_bus.address == BASE_ADDRESS + REG_FB_LENGTH) fb_length       <= io_bus.write_data[COUNT_WIDTH-1:0];
      end
      if (io_bus.read_en) begin
        if (io_bus.address == BASE_ADDRESS + REG_STATUS)
          io_bus.read_data <= {30'b0, overflow, (state != IDLE)};
        else
          io_bus.read_data <= '0;
      end
    end
  end

endmodule
